uart_rx_fsm: RTL and testbench

Receive-side frame controller for the UART RX path. It detects the start of a frame on `RX_IN` and tracks edge and bit position at the oversampling rate. It issues the sampling, deserialisation and check strobes consumed by the data-sampling, deserializer, start-check, parity-check and stop-check stages. It collects their error results and raises `data_valid` for a clean frame. Frame format: 1 start bit, 8 data bits (LSB first), optional parity bit, 1 stop bit.

---
 rtl/uart_rx_fsm.sv | 76 +++++++
 tb/tb_uart_rx_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller; tracks edge/bit position and issues sampling and check strobes.
module uart_rx_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       dat_samp_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_next;
    logic [5:0] p_lat;
    logic       par_lat;
    logic       err;
    logic       last;
    logic       strobe;
    assign last   = edge_cnt == p_lat - 6'd1;
    // first edge at which the 3-sample majority is settled
    assign strobe = edge_cnt == (p_lat >> 1) + 6'd2;
    always_comb begin
        state_next  = state;
        dat_samp_en = state != IDLE;
        strt_chk_en = state == START && strobe;
        deser_en    = state == DATA && strobe;
        par_chk_en  = state == PARITY && strobe;
        stp_chk_en  = state == STOP && strobe;
        case (state)
            IDLE:    state_next = RX_IN ? IDLE : START;
            START:   state_next = !last ? START : (strt_glitch ? IDLE : DATA);
            DATA:    state_next = !(last && bit_cnt == 4'd8) ? DATA : (par_lat ? PARITY : STOP);
            PARITY:  state_next = last ? STOP : PARITY;
            STOP:    state_next = last ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            p_lat      <= '0;
            par_lat    <= 1'b0;
            err        <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_next;
            data_valid <= state == STOP && last && !stp_err && !err;
            if (state == IDLE || state_next == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
            if (state == IDLE && !RX_IN) begin
                p_lat   <= Prescale;
                par_lat <= PAR_EN;
                err     <= 1'b0;
            end
            if (state == PARITY && last)
                err <= err | par_err;
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: table-driven frame scenarios plus back-to-back and mid-frame reset sequences.
module tb_uart_rx_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b1;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fsm dut (
        .clk(clk), .rst_n(rst_n), .RX_IN(rx_in), .Prescale(prescale), .PAR_EN(par_en),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid)
    );

    // expected cycles are relative to cycle 0 = the IDLE cycle that sees RX_IN low; 0 means "never"
    typedef struct {
        int p, pe, dat, gl, perr, serr;
        int n_act, dv_cyc, s, strt_cyc, d_first, d_last, d_n, par_cyc, stp_cyc, stp_bit, max_bit;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({dat_samp_en, edge_cnt, bit_cnt, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid});
    endfunction

    function automatic logic line(vec_t v, int k);
        int b = k / v.p;
        logic [7:0] d = v.dat[7:0];
        if (v.gl != 0) return k >= 3;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && v.pe != 0) return ^d;
        return 1'b1;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int act = 0, first_act = 0, first_edge = -1, dv_n = 0, dv_at = 0, strt_n = 0, strt_at = 0;
        int d_n = 0, d_first = 0, d_last = 0, d_edge_bad = 0, d_bsum = 0;
        int par_n = 0, par_at = 0, stp_n = 0, stp_at = 0, stp_bit = 0, stp_edge = 0, max_bit = 0;
        prescale = 6'(v.p); par_en = v.pe[0]; strt_glitch = v.gl[0]; par_err = v.perr[0]; stp_err = v.serr[0];
        for (int k = 0; k <= v.n_act + 3; k++) begin
            @(negedge clk);
            if (dat_samp_en) begin
                act++;
                if (first_act == 0) begin first_act = k; first_edge = int'(edge_cnt); end
            end
            if (data_valid) begin dv_n++; dv_at = k; end
            if (strt_chk_en) begin strt_n++; strt_at = k; end
            if (deser_en) begin
                d_n++;
                if (d_first == 0) d_first = k;
                d_last = k;
                d_bsum += int'(bit_cnt);
                if (int'(edge_cnt) != v.s) d_edge_bad++;
            end
            if (par_chk_en) begin par_n++; par_at = k; end
            if (stp_chk_en) begin stp_n++; stp_at = k; stp_bit = int'(bit_cnt); stp_edge = int'(edge_cnt); end
            if (int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
            rx_in = line(v, k);
            if (k == 2) begin prescale = 6'd24; par_en = ~v.pe[0]; end
        end
        rx_in = 1'b1; prescale = 6'(v.p); par_en = v.pe[0];
        chk({tag, " active_cycles"}, act, v.n_act);
        chk({tag, " first_active_cycle"}, first_act, 1);
        chk({tag, " first_edge_cnt"}, first_edge, 0);
        chk({tag, " dv_count"}, dv_n, v.dv_cyc != 0 ? 1 : 0);
        chk({tag, " dv_cycle"}, dv_at, v.dv_cyc);
        chk({tag, " strt_count"}, strt_n, 1);
        chk({tag, " strt_cycle"}, strt_at, v.strt_cyc);
        chk({tag, " deser_count"}, d_n, v.d_n);
        chk({tag, " deser_first"}, d_first, v.d_first);
        chk({tag, " deser_last"}, d_last, v.d_last);
        chk({tag, " deser_edge_bad"}, d_edge_bad, 0);
        chk({tag, " deser_bitsum"}, d_bsum, v.d_n == 8 ? 36 : 0);
        chk({tag, " par_count"}, par_n, v.par_cyc != 0 ? 1 : 0);
        chk({tag, " par_cycle"}, par_at, v.par_cyc);
        chk({tag, " stp_count"}, stp_n, v.stp_cyc != 0 ? 1 : 0);
        chk({tag, " stp_cycle"}, stp_at, v.stp_cyc);
        chk({tag, " stp_bit"}, stp_bit, v.stp_bit);
        chk({tag, " stp_edge"}, stp_edge, v.stp_cyc != 0 ? v.s : 0);
        chk({tag, " max_bit"}, max_bit, v.max_bit);
    endtask

    initial begin
        vt[0] = '{8, 1, 'hA5, 0, 0, 0, 88, 89, 6, 7, 15, 71, 8, 79, 87, 10, 10};
        vt[1] = '{8, 1, 'hA5, 0, 1, 0, 88, 0, 6, 7, 15, 71, 8, 79, 87, 10, 10};
        vt[2] = '{16, 0, 'h3C, 0, 1, 0, 160, 161, 10, 11, 27, 139, 8, 0, 155, 9, 9};
        vt[3] = '{8, 1, 'hA5, 1, 0, 0, 8, 0, 6, 7, 0, 0, 0, 0, 0, 0, 0};
        vt[4] = '{8, 1, 'h5A, 0, 0, 1, 88, 0, 6, 7, 15, 71, 8, 79, 87, 10, 10};
        vt[5] = '{32, 1, 'hFF, 0, 0, 0, 352, 353, 18, 19, 51, 275, 8, 307, 339, 10, 10};
        vt[6] = '{10, 0, 'h00, 0, 0, 0, 100, 101, 7, 8, 18, 88, 8, 0, 98, 9, 9};

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", outs(), 0);

        for (int i = 0; i < 7; i++) run_frame(vt[i], $sformatf("vec%0d", i));

        // back-to-back: second start bit lands in the first frame's data_valid cycle
        begin
            int dv_n = 0, dv1 = 0, dv2 = 0;
            prescale = 6'd8; par_en = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
            for (int k = 0; k <= 182; k++) begin
                @(negedge clk);
                if (data_valid) begin
                    dv_n++;
                    if (dv_n == 1) dv1 = k; else dv2 = k;
                end
                if (k == 89) chk("b2b_dv_cycle_idle", int'(dat_samp_en), 0);
                if (k == 90) begin
                    chk("b2b_restart_active", int'(dat_samp_en), 1);
                    chk("b2b_restart_edge", int'(edge_cnt), 0);
                end
                rx_in = line(vt[0], k < 89 ? k : k - 89);
            end
            rx_in = 1'b1;
            chk("b2b_dv_count", dv_n, 2);
            chk("b2b_dv1_cycle", dv1, 89);
            chk("b2b_dv2_cycle", dv2, 178);
        end

        // asynchronous reset in the middle of data bit 4
        begin
            int dv_n = 0, act = 0;
            for (int k = 0; k <= 38; k++) begin
                @(negedge clk);
                if (k == 38) begin
                    chk("rst_pre_bit_cnt", int'(bit_cnt), 4);
                    chk("rst_pre_edge_cnt", int'(edge_cnt), 5);
                end
                rx_in = line(vt[0], k);
            end
            rst_n = 1'b0;
            #1;
            chk("rst_async_outputs", outs(), 0);
            rx_in = 1'b1;
            repeat (3) @(negedge clk);
            chk("rst_held_outputs", outs(), 0);
            rst_n = 1'b1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (data_valid) dv_n++;
                if (dat_samp_en) act++;
            end
            chk("rst_no_dv", dv_n, 0);
            chk("rst_stays_idle", act, 0);
            run_frame(vt[0], "after_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
